// File: rtl/slow_access_ctl.sv
// Slow-access sequencer: on a bus cycle to an enabled slow device, request slow clock,
// optionally stall DTACK until the switcher acknowledges, then hold the request for a
// programmable number of timeout ticks after the access ends.
// Ports: CLK/nPOR clock and async active-low reset; BACT plus six chip selects and six
//        per-device slow enables; SlowClockGate, SlowTimeout[3:0], TimeoutTick, SlowAck;
//        outputs SlowReq, SlowWait (registered), SlowActive (state decode), SlowCount.
module slow_access_ctl (
    input  logic       CLK,
    input  logic       nPOR,
    input  logic       BACT,
    input  logic       IACKCS,
    input  logic       VIACS,
    input  logic       IWMCS,
    input  logic       SCCCS,
    input  logic       SCSICS,
    input  logic       SndCS,
    input  logic       SlowIACK,
    input  logic       SlowVIA,
    input  logic       SlowIWM,
    input  logic       SlowSCC,
    input  logic       SlowSCSI,
    input  logic       SlowSnd,
    input  logic       SlowClockGate,
    input  logic [3:0] SlowTimeout,
    input  logic       TimeoutTick,
    input  logic       SlowAck,
    output logic       SlowReq,
    output logic       SlowWait,
    output logic       SlowActive,
    output logic [3:0] SlowCount
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SYNC   = 2'd1,
        ST_ACCESS = 2'd2,
        ST_HOLD   = 2'd3
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] count_q, count_d;
    logic       bactr_q;
    logic       req_q;
    logic       wait_q;

    logic       hit;
    logic       start;
    state_t     entry_state;

    assign hit = (IACKCS & SlowIACK) | (VIACS & SlowVIA) | (IWMCS & SlowIWM)
               | (SCCCS & SlowSCC) | (SCSICS & SlowSCSI) | (SndCS & SlowSnd);

    // Only the first cycle of a bus cycle can start a slow access; a select that
    // appears later in the same bus cycle is deliberately ignored.
    assign start = BACT & ~bactr_q & hit;

    // If the switcher is already slow (SlowAck high) there is nothing to wait for.
    assign entry_state = (SlowClockGate & ~SlowAck) ? ST_SYNC : ST_ACCESS;

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = entry_state;
                end
            end
            ST_SYNC: begin
                if (SlowAck) begin
                    state_d = ST_ACCESS;
                end else if (!BACT) begin
                    // Aborted cycle: fall into the normal hold-off tail.
                    state_d = ST_HOLD;
                    count_d = SlowTimeout;
                end
            end
            ST_ACCESS: begin
                if (!BACT) begin
                    state_d = ST_HOLD;
                    count_d = SlowTimeout;
                end
            end
            ST_HOLD: begin
                // A retrigger wins over expiry and freezes the count until the next reload.
                if (start) begin
                    state_d = entry_state;
                end else if (count_q == 4'd0) begin
                    state_d = ST_IDLE;
                end else if (TimeoutTick) begin
                    count_d = count_q - 4'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Outputs are registered from the next state so they line up with the state flops.
    always_ff @(posedge CLK or negedge nPOR) begin
        if (!nPOR) begin
            state_q <= ST_IDLE;
            count_q <= 4'd0;
            bactr_q <= 1'b0;
            req_q   <= 1'b0;
            wait_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            bactr_q <= BACT;
            req_q   <= (state_d != ST_IDLE);
            wait_q  <= (state_d == ST_SYNC);
        end
    end

    assign SlowReq    = req_q;
    assign SlowWait   = wait_q;
    assign SlowActive = (state_q != ST_IDLE);
    assign SlowCount  = count_q;

endmodule

// File: tb/tb_slow_access_ctl.sv
// Directed bench for slow_access_ctl: stimulus pushes hand-computed expectations into a
// queue, an independent monitor pops and compares after each clock edge or reset assertion.
module tb_slow_access_ctl;

    logic       CLK = 1'b0;
    logic       nPOR = 1'b0;
    logic       BACT = 1'b0;
    logic       IACKCS = 1'b0, VIACS = 1'b0, IWMCS = 1'b0;
    logic       SCCCS = 1'b0, SCSICS = 1'b0, SndCS = 1'b0;
    logic [5:0] slow_en = 6'b0;
    logic       SlowClockGate = 1'b0;
    logic [3:0] SlowTimeout = 4'd0;
    logic       TimeoutTick = 1'b0;
    logic       SlowAck = 1'b0;
    logic       SlowReq, SlowWait, SlowActive;
    logic [3:0] SlowCount;

    // Chip-select / enable bit order: {IACK, VIA, IWM, SCC, SCSI, Snd}
    localparam logic [5:0] NONE = 6'b000000;
    localparam logic [5:0] VIA  = 6'b010000;
    localparam logic [5:0] IWM  = 6'b001000;
    localparam logic [5:0] SCC  = 6'b000100;

    slow_access_ctl dut (
        .CLK          (CLK),
        .nPOR         (nPOR),
        .BACT         (BACT),
        .IACKCS       (IACKCS),
        .VIACS        (VIACS),
        .IWMCS        (IWMCS),
        .SCCCS        (SCCCS),
        .SCSICS       (SCSICS),
        .SndCS        (SndCS),
        .SlowIACK     (slow_en[5]),
        .SlowVIA      (slow_en[4]),
        .SlowIWM      (slow_en[3]),
        .SlowSCC      (slow_en[2]),
        .SlowSCSI     (slow_en[1]),
        .SlowSnd      (slow_en[0]),
        .SlowClockGate(SlowClockGate),
        .SlowTimeout  (SlowTimeout),
        .TimeoutTick  (TimeoutTick),
        .SlowAck      (SlowAck),
        .SlowReq      (SlowReq),
        .SlowWait     (SlowWait),
        .SlowActive   (SlowActive),
        .SlowCount    (SlowCount)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        int         idx;
        logic [6:0] exp;   // {SlowReq, SlowWait, SlowActive, SlowCount}
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   vec_n  = 0;

    function automatic logic [6:0] E(input logic r, input logic w, input logic a,
                                     input logic [3:0] c);
        return {r, w, a, c};
    endfunction

    // Drive one cycle of inputs at the falling edge; expectation is for the next rising edge.
    task automatic step(input logic b, input logic [5:0] cs, input logic t, input logic a,
                        input logic [6:0] e);
        exp_t x;
        BACT = b;
        {IACKCS, VIACS, IWMCS, SCCCS, SCSICS, SndCS} = cs;
        TimeoutTick = t;
        SlowAck = a;
        x.idx = vec_n;
        x.exp = e;
        exp_q.push_back(x);
        vec_n++;
        @(negedge CLK);
    endtask

    // Monitor: compares whenever the DUT outputs can have changed.
    initial begin
        exp_t       x;
        logic [6:0] act;
        forever begin
            @(posedge CLK or negedge nPOR);
            #1;
            if (exp_q.size() > 0) begin
                x   = exp_q.pop_front();
                act = {SlowReq, SlowWait, SlowActive, SlowCount};
                checks++;
                if (act !== x.exp) begin
                    errors++;
                    $display("FAIL vec%0d req/wait/act/cnt got %b/%b/%b/%0d want %b/%b/%b/%0d",
                             x.idx, act[6], act[5], act[4], act[3:0],
                             x.exp[6], x.exp[5], x.exp[4], x.exp[3:0]);
                end
            end
        end
    end

    initial begin
        exp_t x;
        @(negedge CLK);

        // Power-on reset held, then released
        step(0, NONE, 0, 0, E(0,0,0,0));
        step(0, NONE, 0, 0, E(0,0,0,0));
        nPOR = 1'b1;
        step(0, NONE, 0, 0, E(0,0,0,0));
        step(0, NONE, 0, 0, E(0,0,0,0));

        // Gated access: SYNC until SlowAck, then ACCESS; hold-off count 3
        SlowClockGate = 1'b1;
        slow_en       = VIA;
        SlowTimeout   = 4'd3;
        step(1, VIA,  0, 0, E(1,1,1,0));
        step(1, VIA,  0, 0, E(1,1,1,0));
        step(1, VIA,  0, 0, E(1,1,1,0));
        step(1, VIA,  0, 0, E(1,1,1,0));
        step(1, VIA,  0, 0, E(1,1,1,0));
        step(1, VIA,  0, 1, E(1,0,1,0));   // SlowAck sampled -> SlowWait drops
        step(1, VIA,  0, 1, E(1,0,1,0));
        step(0, NONE, 1, 1, E(1,0,1,3));   // load; tick on load cycle ignored
        step(0, NONE, 1, 1, E(1,0,1,2));
        step(1, IWM,  0, 1, E(1,0,1,2));   // non-slow bus cycle in HOLD
        step(1, IWM,  1, 1, E(1,0,1,1));
        step(0, NONE, 0, 1, E(1,0,1,1));
        step(0, NONE, 1, 1, E(1,0,1,0));
        step(0, NONE, 1, 1, E(0,0,0,0));   // expiry; tick here does not wrap
        step(0, NONE, 0, 0, E(0,0,0,0));

        // Disabled device, and a select arriving late in the bus cycle
        step(1, IWM,  0, 0, E(0,0,0,0));
        step(1, VIA,  0, 0, E(0,0,0,0));
        step(0, NONE, 0, 0, E(0,0,0,0));

        // Ungated SCC access with timeout 0: exactly one HOLD cycle
        SlowClockGate = 1'b0;
        slow_en       = VIA | SCC;
        SlowTimeout   = 4'd0;
        step(1, SCC,  0, 0, E(1,0,1,0));
        step(1, SCC,  0, 0, E(1,0,1,0));
        step(0, NONE, 0, 0, E(1,0,1,0));
        step(0, NONE, 0, 0, E(0,0,0,0));
        step(0, NONE, 0, 0, E(0,0,0,0));

        // Retrigger in HOLD with SlowAck already high; new timeout taken at next load
        SlowClockGate = 1'b1;
        SlowTimeout   = 4'd2;
        step(1, VIA,  0, 1, E(1,0,1,0));
        step(0, NONE, 0, 1, E(1,0,1,2));
        step(0, NONE, 1, 1, E(1,0,1,1));
        SlowTimeout   = 4'd5;
        step(1, VIA,  1, 1, E(1,0,1,1));   // start beats tick, count frozen
        step(1, VIA,  1, 1, E(1,0,1,1));
        step(0, NONE, 0, 1, E(1,0,1,5));
        step(0, NONE, 1, 1, E(1,0,1,4));
        step(0, NONE, 1, 1, E(1,0,1,3));
        step(0, NONE, 1, 1, E(1,0,1,2));
        step(0, NONE, 1, 1, E(1,0,1,1));
        step(0, NONE, 1, 1, E(1,0,1,0));
        step(0, NONE, 0, 1, E(0,0,0,0));

        // Aborted cycle in SYNC, then retrigger into SYNC from HOLD
        SlowTimeout   = 4'd4;
        step(1, VIA,  0, 0, E(1,1,1,0));
        step(1, VIA,  0, 0, E(1,1,1,0));
        step(0, NONE, 0, 0, E(1,0,1,4));
        step(0, NONE, 1, 0, E(1,0,1,3));
        step(1, VIA,  0, 0, E(1,1,1,3));
        step(1, VIA,  0, 0, E(1,1,1,3));

        // Asynchronous reset mid-SYNC, away from any clock edge
        #2;
        x.idx = vec_n;
        x.exp = E(0,0,0,0);
        exp_q.push_back(x);
        vec_n++;
        nPOR = 1'b0;
        @(negedge CLK);
        step(0, NONE, 0, 0, E(0,0,0,0));
        nPOR = 1'b1;
        step(0, NONE, 0, 0, E(0,0,0,0));
        SlowClockGate = 1'b0;
        step(1, VIA,  0, 0, E(1,0,1,0));   // IDLE after reset accepts a new access
        step(0, NONE, 0, 0, E(1,0,1,4));

        @(posedge CLK);
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain pending got %0d want 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
